bc_fir_tap_line: RTL and testbench

- Upstream feeder for the binary symmetric half-band FIR stage.
- Accepts one binary sample per valid/ready handshake and shifts it into a TAPS-deep delay line.
- Presents the whole delay line in parallel as the FIR's 39-element input array.
- Asserts taps_valid only when the line holds a complete window and the decimation phase is due, so the combinational FIR output is sampled at the correct rate.

---
 rtl/bc_fir_tap_line_if.sv | 25 ++
 rtl/bc_fir_tap_line.sv | 81 ++++++++
 tb/tb_bc_fir_tap_line.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bc_fir_tap_line_if.sv
// Sample-in / window-out bundle between the tap line, its feeder and the FIR consumer.
interface bc_fir_tap_line_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned TAPS = 39
);
  localparam int unsigned FW = $clog2(TAPS + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [N-1:0]  taps [TAPS-1:0];
  logic          taps_valid;
  logic          out_ready;
  logic [FW-1:0] fill_level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, taps, taps_valid, fill_level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, taps, taps_valid, fill_level
  );
endinterface

// File: rtl/bc_fir_tap_line.sv
// TAPS-deep sample delay line feeding the half-band FIR, with fill tracking
// and decimated window-valid generation under a single-entry valid/ready hold.
module bc_fir_tap_line #(
  parameter int unsigned N         = 8,
  parameter int unsigned TAPS      = 39,
  parameter int unsigned DECIM     = 2,
  parameter int unsigned ZERO_FILL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  bc_fir_tap_line_if.slave  bus
);
  localparam int unsigned FW = $clog2(TAPS + 1);
  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [N-1:0]  taps_q [TAPS-1:0];
  logic [N-1:0]  taps_d [TAPS-1:0];
  logic [FW-1:0] fill_level_q, fill_level_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          taps_valid_q, taps_valid_d;

  logic          in_ready_c;
  logic          accept_c;
  logic          full_c;
  logic [FW-1:0] fill_inc_c;

  // Single-entry hold: a new sample may only enter once the window is consumed.
  assign in_ready_c = !taps_valid_q || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c && !flush;

  always_comb begin
    taps_d       = taps_q;
    fill_level_d = fill_level_q;
    phase_d      = phase_q;
    taps_valid_d = taps_valid_q;
    fill_inc_c   = (fill_level_q == FW'(TAPS)) ? fill_level_q : fill_level_q + FW'(1);
    full_c       = (fill_inc_c == FW'(TAPS)) || (ZERO_FILL != 0);

    if (flush) begin
      for (int unsigned k = 0; k < TAPS; k++) taps_d[k] = '0;
      fill_level_d = '0;
      phase_d      = '0;
      taps_valid_d = 1'b0;
    end else begin
      if (accept_c) begin
        taps_d[0] = bus.in_data;
        for (int unsigned k = 1; k < TAPS; k++) taps_d[k] = taps_q[k-1];
        fill_level_d = fill_inc_c;
        if (full_c) begin
          phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
      end
      // A freshly produced window wins over a same-cycle consume.
      if (accept_c && full_c && (phase_q == '0)) begin
        taps_valid_d = 1'b1;
      end else if (bus.out_ready) begin
        taps_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TAPS; k++) taps_q[k] <= '0;
      fill_level_q <= '0;
      phase_q      <= '0;
      taps_valid_q <= 1'b0;
    end else begin
      taps_q       <= taps_d;
      fill_level_q <= fill_level_d;
      phase_q      <= phase_d;
      taps_valid_q <= taps_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.taps       = taps_q;
  assign bus.taps_valid = taps_valid_q;
  assign bus.fill_level = fill_level_q;
endmodule

// File: tb/tb_bc_fir_tap_line.sv
// Bench for bc_fir_tap_line: three instances (DECIM=1, DECIM=2, ZERO_FILL=1)
// exercised by scenario tasks with a queue of expected windows.
module tb_bc_fir_tap_line;
  localparam int unsigned N    = 8;
  localparam int unsigned TAPS = 39;
  localparam int unsigned FW   = $clog2(TAPS + 1);

  typedef struct {
    int           k;
    logic [N-1:0] t0;
    logic [N-1:0] t19;
    logic [N-1:0] t38;
    logic [FW-1:0] fill;
    logic         vld;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush_d1, flush_d2, flush_zf;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  logic          obs_valid, obs_ready;
  logic [FW-1:0] obs_fill;
  logic [N-1:0]  obs_taps [TAPS-1:0];
  int            obs_nz;

  bc_fir_tap_line_if #(.N(N), .TAPS(TAPS)) if_d1 ();
  bc_fir_tap_line_if #(.N(N), .TAPS(TAPS)) if_d2 ();
  bc_fir_tap_line_if #(.N(N), .TAPS(TAPS)) if_zf ();

  bc_fir_tap_line #(.N(N), .TAPS(TAPS), .DECIM(1), .ZERO_FILL(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush_d1), .bus(if_d1));
  bc_fir_tap_line #(.N(N), .TAPS(TAPS), .DECIM(2), .ZERO_FILL(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush_d2), .bus(if_d2));
  bc_fir_tap_line #(.N(N), .TAPS(TAPS), .DECIM(1), .ZERO_FILL(1)) u_zf (
    .clk(clk), .rst_n(rst_n), .flush(flush_zf), .bus(if_zf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected window after the k-th accept of the stream 1,2,3,...
  function automatic exp_t mk_exp(input int k, input int decim);
    exp_t e;
    e.k    = k;
    e.t0   = (k >= 1)  ? N'(k)      : '0;
    e.t19  = (k >= 20) ? N'(k - 19) : '0;
    e.t38  = (k >= 39) ? N'(k - 38) : '0;
    e.fill = FW'((k < 39) ? k : 39);
    e.vld  = (k >= 39) && (((k - 39) % decim) == 0);
    return e;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [N-1:0] d,
                        input logic ordy, input logic fl);
    case (sel)
      1: begin if_d1.in_valid = v; if_d1.in_data = d; if_d1.out_ready = ordy; flush_d1 = fl; end
      2: begin if_d2.in_valid = v; if_d2.in_data = d; if_d2.out_ready = ordy; flush_d2 = fl; end
      default: begin if_zf.in_valid = v; if_zf.in_data = d; if_zf.out_ready = ordy; flush_zf = fl; end
    endcase
  endtask

  task automatic grab(input int sel);
    case (sel)
      1: begin obs_valid = if_d1.taps_valid; obs_ready = if_d1.in_ready; obs_fill = if_d1.fill_level;
               for (int i = 0; i < TAPS; i++) obs_taps[i] = if_d1.taps[i]; end
      2: begin obs_valid = if_d2.taps_valid; obs_ready = if_d2.in_ready; obs_fill = if_d2.fill_level;
               for (int i = 0; i < TAPS; i++) obs_taps[i] = if_d2.taps[i]; end
      default: begin obs_valid = if_zf.taps_valid; obs_ready = if_zf.in_ready; obs_fill = if_zf.fill_level;
               for (int i = 0; i < TAPS; i++) obs_taps[i] = if_zf.taps[i]; end
    endcase
    obs_nz = 0;
    for (int i = 1; i < TAPS; i++) if (obs_taps[i] !== '0) obs_nz++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int s = 1; s <= 3; s++) set_in(s, 1'b0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 1; s <= 3; s++) begin
      grab(s);
      total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid inst=%0d got=%b want=0", s, obs_valid); end
      total++; if (obs_fill !== '0) begin bad++; $display("FAIL reset_fill inst=%0d got=%0d want=0", s, obs_fill); end
      total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL reset_ready inst=%0d got=%b want=1", s, obs_ready); end
      total++; if (obs_taps[0] !== '0 || obs_nz != 0) begin bad++; $display("FAIL reset_taps inst=%0d t0=%h nonzero=%0d want all 0", s, obs_taps[0], obs_nz); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_d1;
    exp_t e;
    for (int k = 1; k <= 39; k++) begin
      set_in(1, 1'b1, N'(k), 1'b1, 1'b0);
      sbq.push_back(mk_exp(k, 1));
      @(posedge clk); #1;
      grab(1);
      total++;
      if (sbq.size() == 0) begin bad++; $display("FAIL fill_sb_empty k=%0d", k); end
      else begin
        e = sbq.pop_front();
        if (obs_valid !== e.vld) begin bad++; $display("FAIL fill_valid k=%0d got=%b want=%b", k, obs_valid, e.vld); end
        total++; if (obs_taps[0] !== e.t0) begin bad++; $display("FAIL fill_t0 k=%0d got=%0d want=%0d", k, obs_taps[0], e.t0); end
        total++; if (obs_taps[19] !== e.t19) begin bad++; $display("FAIL fill_t19 k=%0d got=%0d want=%0d", k, obs_taps[19], e.t19); end
        total++; if (obs_taps[38] !== e.t38) begin bad++; $display("FAIL fill_t38 k=%0d got=%0d want=%0d", k, obs_taps[38], e.t38); end
        total++; if (obs_fill !== e.fill) begin bad++; $display("FAIL fill_level k=%0d got=%0d want=%0d", k, obs_fill, e.fill); end
      end
    end
    set_in(1, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_decim;
    exp_t e;
    for (int k = 1; k <= 43; k++) begin
      set_in(2, 1'b1, N'(k), 1'b1, 1'b0);
      sbq.push_back(mk_exp(k, 2));
      @(posedge clk); #1;
      grab(2);
      total++;
      if (sbq.size() == 0) begin bad++; $display("FAIL decim_sb_empty k=%0d", k); end
      else begin
        e = sbq.pop_front();
        if (obs_valid !== e.vld) begin bad++; $display("FAIL decim_valid k=%0d got=%b want=%b", k, obs_valid, e.vld); end
        total++; if (obs_taps[0] !== e.t0) begin bad++; $display("FAIL decim_t0 k=%0d got=%0d want=%0d", k, obs_taps[0], e.t0); end
        total++; if (obs_taps[38] !== e.t38) begin bad++; $display("FAIL decim_t38 k=%0d got=%0d want=%0d", k, obs_taps[38], e.t38); end
        total++; if (obs_fill !== e.fill) begin bad++; $display("FAIL decim_fill k=%0d got=%0d want=%0d", k, obs_fill, e.fill); end
      end
    end
    // Hold the last window so the async-reset scenario starts with taps_valid = 1.
    set_in(2, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    exp_t e;
    set_in(1, 1'b1, N'(40), 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(1, 1'b1, 8'hAA, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1; grab(1);
      total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0", c, obs_ready); end
      @(posedge clk); #1;
      grab(1);
      total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", c, obs_valid); end
      total++; if (obs_taps[0] !== N'(40) || obs_taps[1] !== N'(39)) begin
        bad++; $display("FAIL bp_frozen cyc=%0d t0=%0d t1=%0d want t0=40 t1=39", c, obs_taps[0], obs_taps[1]);
      end
    end
    set_in(1, 1'b1, 8'hAA, 1'b1, 1'b0);
    e.k = 41; e.t0 = 8'hAA; e.t19 = N'(22); e.t38 = N'(3); e.fill = FW'(39); e.vld = 1'b1;
    sbq.push_back(e);
    #1; grab(1);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", obs_ready); end
    @(posedge clk); #1;
    grab(1);
    set_in(1, 1'b0, '0, 1'b1, 1'b0);
    total++;
    if (sbq.size() == 0) begin bad++; $display("FAIL bp_sb_empty"); end
    else begin
      e = sbq.pop_front();
      if (obs_taps[0] !== e.t0) begin bad++; $display("FAIL bp_accept_t0 got=%h want=%h", obs_taps[0], e.t0); end
      total++; if (obs_taps[1] !== N'(40)) begin bad++; $display("FAIL bp_accept_t1 got=%0d want=40", obs_taps[1]); end
      total++; if (obs_taps[19] !== e.t19 || obs_taps[38] !== e.t38) begin
        bad++; $display("FAIL bp_accept_old t19=%0d t38=%0d want %0d %0d", obs_taps[19], obs_taps[38], e.t19, e.t38);
      end
      total++; if (obs_valid !== e.vld) begin bad++; $display("FAIL bp_accept_valid got=%b want=%b", obs_valid, e.vld); end
      total++; if (obs_fill !== e.fill) begin bad++; $display("FAIL bp_accept_fill got=%0d want=%0d", obs_fill, e.fill); end
    end
  endtask

  task automatic test_zero_fill;
    set_in(3, 1'b1, 8'h7F, 1'b1, 1'b0);
    @(posedge clk); #1;
    grab(3);
    set_in(3, 1'b0, '0, 1'b1, 1'b0);
    total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL zf_valid got=%b want=1", obs_valid); end
    total++; if (obs_taps[0] !== 8'h7F) begin bad++; $display("FAIL zf_t0 got=%h want=7f", obs_taps[0]); end
    total++; if (obs_nz != 0) begin bad++; $display("FAIL zf_history nonzero=%0d want=0", obs_nz); end
    total++; if (obs_fill !== FW'(1)) begin bad++; $display("FAIL zf_fill got=%0d want=1", obs_fill); end
  endtask

  task automatic test_flush;
    set_in(1, 1'b1, 8'h55, 1'b1, 1'b1);
    #1; grab(1);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", obs_ready); end
    total++; if (obs_fill !== FW'(39)) begin bad++; $display("FAIL flush_prefill got=%0d want=39", obs_fill); end
    @(posedge clk); #1;
    grab(1);
    set_in(1, 1'b0, '0, 1'b1, 1'b0);
    total++; if (obs_taps[0] !== '0 || obs_nz != 0) begin bad++; $display("FAIL flush_taps t0=%h nonzero=%0d want all 0", obs_taps[0], obs_nz); end
    total++; if (obs_fill !== '0) begin bad++; $display("FAIL flush_fill got=%0d want=0", obs_fill); end
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", obs_valid); end
    @(posedge clk); #1;
    grab(1);
    total++; if (obs_fill !== '0 || obs_taps[0] !== '0) begin bad++; $display("FAIL flush_after fill=%0d t0=%h want 0 0", obs_fill, obs_taps[0]); end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #3;
    grab(2);
    total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b want=1", obs_valid); end
    rst_n = 1'b0;
    #1;
    grab(2);
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", obs_valid); end
    total++; if (obs_fill !== '0) begin bad++; $display("FAIL ar_fill got=%0d want=0", obs_fill); end
    total++; if (obs_taps[0] !== '0 || obs_nz != 0) begin bad++; $display("FAIL ar_taps t0=%h nonzero=%0d want all 0", obs_taps[0], obs_nz); end
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b want=1", obs_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    test_fill_d1();
  endtask

  initial begin
    flush_d1 = 1'b0; flush_d2 = 1'b0; flush_zf = 1'b0;
    test_reset();
    test_fill_d1();
    test_decim();
    test_backpressure();
    test_zero_fill();
    test_flush();
    test_async_reset();
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
